// File: rtl/ram_tdp_be.sv
// True dual-port RAM with byte-lane writes, 1- or 2-cycle registered reads,
// selectable same-port read-during-write and fixed-priority write collisions.
module ram_tdp_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    parameter int COLL_PRI   = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               a_en,
    input  logic                               a_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   a_be,
    input  logic [ADDR_WIDTH-1:0]              a_addr,
    input  logic [DATA_WIDTH-1:0]              a_din,
    output logic [DATA_WIDTH-1:0]              a_dout,
    output logic                               a_dout_vld,
    input  logic                               b_en,
    input  logic                               b_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   b_be,
    input  logic [ADDR_WIDTH-1:0]              b_addr,
    input  logic [DATA_WIDTH-1:0]              b_din,
    output logic [DATA_WIDTH-1:0]              b_dout,
    output logic                               b_dout_vld,
    output logic                               collision,
    output logic                               init_done
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic                    run;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    a_wr, b_wr, same_addr, a_req, b_req;
    logic [NB-1:0]           a_lane, b_lane, overlap, a_eff, b_eff;
    logic [DATA_WIDTH-1:0]   a_old, b_old, a_new, b_new, a_rdata, b_rdata;
    logic [DATA_WIDTH-1:0]   a_s1_q, b_s1_q;
    logic                    a_s1_vld_q, b_s1_vld_q;
    logic                    collision_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == '1) state_d = ST_RUN;
        end
    end

    always_comb begin
        run       = (state_q == ST_RUN);
        init_done = run;
    end

    // Losing port's overlapping lanes are masked so only the winner writes them.
    always_comb begin
        a_wr      = run & a_en & a_we;
        b_wr      = run & b_en & b_we;
        a_req     = run & a_en;
        b_req     = run & b_en;
        same_addr = (a_addr == b_addr);
        a_lane    = a_be & {NB{a_wr}};
        b_lane    = b_be & {NB{b_wr}};
        overlap   = same_addr ? (a_lane & b_lane) : '0;
        a_eff     = a_lane;
        b_eff     = b_lane;
        if (COLL_PRI == 0) b_eff = b_lane & ~overlap;
        else               a_eff = a_lane & ~overlap;
    end

    always_comb begin
        a_old = mem_q[a_addr];
        b_old = mem_q[b_addr];
        a_new = a_old;
        b_new = b_old;
        for (int unsigned i = 0; i < NB; i++) begin
            if (a_eff[i])
                a_new[i*BYTE_WIDTH +: BYTE_WIDTH] = a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            else if (same_addr && b_eff[i])
                a_new[i*BYTE_WIDTH +: BYTE_WIDTH] = b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (b_eff[i])
                b_new[i*BYTE_WIDTH +: BYTE_WIDTH] = b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            else if (same_addr && a_eff[i])
                b_new[i*BYTE_WIDTH +: BYTE_WIDTH] = a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        a_rdata = (RDW_MODE == 0 && a_we) ? a_new : a_old;
        b_rdata = (RDW_MODE == 0 && b_we) ? b_new : b_old;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) mem_q[init_cnt_q] <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                if (a_eff[i])
                    mem_q[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (b_eff[i])
                    mem_q[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_s1_q      <= '0;
            b_s1_q      <= '0;
            a_s1_vld_q  <= 1'b0;
            b_s1_vld_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            a_s1_vld_q  <= a_req;
            b_s1_vld_q  <= b_req;
            collision_q <= |overlap;
            if (a_req) a_s1_q <= a_rdata;
            if (b_req) b_s1_q <= b_rdata;
        end
    end

    assign collision = collision_q;

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] a_s2_q, b_s2_q;
        logic                  a_s2_vld_q, b_s2_vld_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                a_s2_q     <= '0;
                b_s2_q     <= '0;
                a_s2_vld_q <= 1'b0;
                b_s2_vld_q <= 1'b0;
            end else begin
                a_s2_vld_q <= a_s1_vld_q;
                b_s2_vld_q <= b_s1_vld_q;
                if (a_s1_vld_q) a_s2_q <= a_s1_q;
                if (b_s1_vld_q) b_s2_q <= b_s1_q;
            end
        end

        assign a_dout     = a_s2_q;
        assign a_dout_vld = a_s2_vld_q;
        assign b_dout     = b_s2_q;
        assign b_dout_vld = b_s2_vld_q;
    end else begin : g_lat1
        assign a_dout     = a_s1_q;
        assign a_dout_vld = a_s1_vld_q;
        assign b_dout     = b_s1_q;
        assign b_dout_vld = b_s1_vld_q;
    end
endmodule

// File: tb/tb_ram_tdp_be.sv
// Scoreboard bench: two RAM configurations share stimulus; a word-level model
// predicts read data and collisions, a negedge monitor checks the DUT outputs.
module tb_ram_tdp_be;
    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
    logic [3:0]  a_be = '0, b_be = '0, a_addr = '0, b_addr = '0;
    logic [31:0] a_din = '0, b_din = '0;

    logic [1:0][31:0] a_dout, b_dout;
    logic [1:0]       a_vld, b_vld, coll, idone;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   icnt  = 0;
    logic rst_seen = 1'b1;

    exp_t        q[2][2][$];
    logic [31:0] last_d[2][2];
    bit          coll_exp[2][4096];
    logic [31:0] mdl[2][16];

    always #5 clk = ~clk;

    ram_tdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
                 .RD_LATENCY(1), .RDW_MODE(0), .COLL_PRI(0)) dut0 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout[0]), .a_dout_vld(a_vld[0]),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout[0]), .b_dout_vld(b_vld[0]),
        .collision(coll[0]), .init_done(idone[0]));

    ram_tdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
                 .RD_LATENCY(2), .RDW_MODE(1), .COLL_PRI(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout[1]), .a_dout_vld(a_vld[1]),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout[1]), .b_dout_vld(b_vld[1]),
        .collision(coll[1]), .init_done(idone[1]));

    function automatic int lat(int k);  return (k == 0) ? 1 : 2; endfunction
    function automatic int rdw(int k);  return (k == 0) ? 0 : 1; endfunction
    function automatic int pri(int k);  return (k == 0) ? 0 : 1; endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] din, logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = din[i*8 +: 8];
        return r;
    endfunction

    // Reference cycle bookkeeping: edges since reset release, saturating at DEPTH.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
        if (rst)            icnt <= 0;
        else if (icnt < 16) icnt <= icnt + 1;
    end

    task automatic chk(input int k, input int p, input logic v, input logic [31:0] d);
        string nm = (p == 0) ? "a_dout" : "b_dout";
        if (rst_seen) begin
            tests += 2;
            if (v !== 1'b0) begin fails++; $display("FAIL %s_vld_reset dut%0d got=%b exp=0", nm, k, v); end
            if (d !== 32'h0) begin fails++; $display("FAIL %s_reset dut%0d got=%h exp=0", nm, k, d); end
            last_d[k][p] = '0;
        end else if (v === 1'b1) begin
            tests++;
            if (q[k][p].size() == 0 || q[k][p][0].due != cyc) begin
                fails++;
                $display("FAIL %s_unexpected_vld dut%0d cyc=%0d got=%h exp=no_valid", nm, k, cyc, d);
            end else begin
                if (d !== q[k][p][0].data) begin
                    fails++;
                    $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, k, cyc, d, q[k][p][0].data);
                end
                last_d[k][p] = q[k][p][0].data;
                void'(q[k][p].pop_front());
            end
        end else begin
            tests++;
            if (v !== 1'b0) begin
                fails++; $display("FAIL %s_vld dut%0d cyc=%0d got=%b exp=0", nm, k, cyc, v);
            end else if (q[k][p].size() != 0 && q[k][p][0].due <= cyc) begin
                fails++;
                $display("FAIL %s_missing_vld dut%0d cyc=%0d got=0 exp=%h", nm, k, cyc, q[k][p][0].data);
                void'(q[k][p].pop_front());
            end else if (d !== last_d[k][p]) begin
                fails++;
                $display("FAIL %s_hold dut%0d cyc=%0d got=%h exp=%h", nm, k, cyc, d, last_d[k][p]);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk(k, 0, a_vld[k], a_dout[k]);
            chk(k, 1, b_vld[k], b_dout[k]);
            tests += 2;
            if (coll[k] !== (rst_seen ? 1'b0 : coll_exp[k][cyc % 4096])) begin
                fails++;
                $display("FAIL collision dut%0d cyc=%0d got=%b exp=%b", k, cyc, coll[k],
                         rst_seen ? 1'b0 : coll_exp[k][cyc % 4096]);
            end
            if (idone[k] !== (icnt == 16)) begin
                fails++;
                $display("FAIL init_done dut%0d cyc=%0d got=%b exp=%b", k, cyc, idone[k], icnt == 16);
            end
        end
    end

    task automatic step(input bit r,
                        input bit ae, input bit awe, input logic [3:0] abe,
                        input logic [3:0] aad, input logic [31:0] ad,
                        input bit ben, input bit bwe, input logic [3:0] bbe,
                        input logic [3:0] bad, input logic [31:0] bd);
        logic [31:0] nw[16];
        rst = r;
        a_en = ae; a_we = awe; a_be = abe; a_addr = aad; a_din = ad;
        b_en = ben; b_we = bwe; b_be = bbe; b_addr = bad; b_din = bd;
        for (int k = 0; k < 2; k++) begin
            coll_exp[k][(cyc + 1) % 4096] = 1'b0;
            if (r) begin
                for (int p = 0; p < 2; p++)
                    while (q[k][p].size() != 0 && q[k][p][$].due > cyc)
                        void'(q[k][p].pop_back());
            end else if (icnt < 16) begin
                mdl[k][icnt] = '0;
            end else begin
                for (int i = 0; i < 16; i++) nw[i] = mdl[k][i];
                // The priority port writes last, so its bytes survive.
                if (pri(k) == 0) begin
                    if (ben && bwe) nw[bad] = merge(nw[bad], bd, bbe);
                    if (ae && awe)  nw[aad] = merge(nw[aad], ad, abe);
                end else begin
                    if (ae && awe)  nw[aad] = merge(nw[aad], ad, abe);
                    if (ben && bwe) nw[bad] = merge(nw[bad], bd, bbe);
                end
                if (ae)  q[k][0].push_back('{cyc + lat(k), (awe && rdw(k) == 0) ? nw[aad] : mdl[k][aad]});
                if (ben) q[k][1].push_back('{cyc + lat(k), (bwe && rdw(k) == 0) ? nw[bad] : mdl[k][bad]});
                coll_exp[k][(cyc + 1) % 4096] = ae && awe && ben && bwe && (aad == bad) && ((abe & bbe) != 0);
                for (int i = 0; i < 16; i++) mdl[k][i] = nw[i];
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 0);
    endtask

    task automatic rd(input logic [3:0] aa, input logic [3:0] ba);
        step(0, 1, 0, 4'h0, aa, 0, 1, 0, 4'h0, ba, 0);
    endtask

    task automatic rnd_step(input bit narrow);
        step(0, 1'($urandom), 1'($urandom), 4'($urandom),
             narrow ? 4'($urandom_range(0, 3)) : 4'($urandom), $urandom,
             1'($urandom), 1'($urandom), 4'($urandom),
             narrow ? 4'($urandom_range(0, 3)) : 4'($urandom), $urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) mdl[k][i] = 32'hDEAD_0000 | i;
        @(negedge clk);
        step(1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 0);
        // Requests during the sweep are dropped.
        step(0, 1, 1, 4'hF, 4'h2, 32'h12345678, 1, 0, 4'h0, 4'h2, 0);
        step(0, 1, 0, 4'h0, 4'h9, 0, 1, 1, 4'hF, 4'h9, 32'h87654321);
        idle(14);
        for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i));
        idle(2);

        step(0, 1, 1, 4'hF, 4'h3, 32'h11223344, 0, 0, 4'h0, 4'h0, 0);
        step(0, 1, 1, 4'h5, 4'h3, 32'hAABBCCDD, 0, 0, 4'h0, 4'h0, 0);
        rd(4'h3, 4'h3);
        idle(2);

        step(0, 1, 1, 4'hF, 4'h5, 32'hCAFEF00D, 1, 0, 4'h0, 4'h5, 0);
        rd(4'h5, 4'h5);
        idle(2);

        step(0, 1, 1, 4'hE, 4'h7, 32'hAAAAAAAA, 1, 1, 4'h7, 4'h7, 32'hBBBBBBBB);
        rd(4'h7, 4'h7);
        step(0, 1, 1, 4'h0, 4'h7, 32'h01010101, 1, 1, 4'hF, 4'h7, 32'h02020202);
        step(0, 1, 1, 4'h3, 4'h8, 32'h03030303, 1, 1, 4'hC, 4'h8, 32'h04040404);
        rd(4'h7, 4'h8);
        idle(3);

        for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i));
        idle(4);

        for (int i = 0; i < 500; i++) rnd_step(i % 2 == 0);
        for (int i = 0; i < 16; i++)
            step(0, 1, 1, 4'hF, 4'(i), 32'h5A000000 | i, 0, 0, 4'h0, 4'h0, 0);

        for (int i = 0; i < 3; i++) rd(4'(i), 4'(i + 4));
        step(1, 1, 0, 4'h0, 4'h1, 0, 1, 0, 4'h0, 4'h2, 0);
        step(1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 0);
        for (int i = 0; i < 16; i++) rnd_step(1'b0);
        for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i));
        idle(4);

        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                tests++;
                if (q[k][p].size() != 0) begin
                    fails++;
                    $display("FAIL drain dut%0d port%0d got=%0d pending exp=0", k, p, q[k][p].size());
                end
            end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ram_tdp_be.md
# ram_tdp_be

Parametrised true dual-port RAM with per-byte write enables, selectable read latency, a selectable read-during-write mode, deterministic write-collision resolution and a self-clearing initialisation sweep. It replaces the fixed-width dual-port RAM used for crossbar bookkeeping, such as ID/CAM tables and reorder storage. It adds byte-lane writes and pipelined reads for wider AXI data paths. It sits between crossbar control logic on both ports and contains no AXI protocol logic of its own.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words
- BYTE_WIDTH, 8, bits per byte lane; NB = DATA_WIDTH/BYTE_WIDTH
- RD_LATENCY, 1, read latency in cycles; legal values are 1 or 2
- RDW_MODE, 0, same-port read-during-write: 0 = write-first, 1 = read-first
- COLL_PRI, 0, winner of same-address, same-lane double write: 0 = port A, 1 = port B

Ports:
- clk  in  1  sole clock; everything samples on its rising edge
- rst  in  1  reset, synchronous, active-high
- a_en  in  1  port A request this cycle
- a_we  in  1  port A write; ignored when a_en=0
- a_be  in  NB  port A byte-lane write enables
- a_addr  in  ADDR_WIDTH  port A address
- a_din  in  DATA_WIDTH  port A write data
- a_dout  out  DATA_WIDTH  port A read data
- a_dout_vld  out  1  a_dout carries the result of a request
- b_*  same set as port A, for port B
- collision  out  1  one-cycle pulse flagging a same-address double write
- init_done  out  1  memory sweep finished; ports accepted

## Operation
- **State machine INIT/RUN.**
  - rst=1 forces INIT and clears init_cnt to 0. Memory is not written while rst=1.
  - In INIT, each edge with rst=0 writes all-zeros to mem[init_cnt] and increments init_cnt.
  - The edge that writes address DEPTH-1 moves the state to RUN and sets init_done=1.
- **Requests during INIT** are dropped: no write occurs and the matching dout_vld stays 0.
- **Write in RUN** (x_en=1, x_we=1): for each lane i with x_be[i]=1, mem[x_addr][i] takes x_din[i]. Lanes with x_be[i]=0 are unchanged. x_be=0 with x_we=1 writes nothing but still returns read data.
- **Read in RUN** (x_en=1, x_we=0): returns mem[x_addr] as it was before this edge.
- **Same-port read-during-write** (x_en=1, x_we=1):
  - RDW_MODE=0: dout is the word as stored after the edge, with collision resolution applied.
  - RDW_MODE=1: dout is the word before the edge.
- **Cross-port, same address, one port writing:** the reading port always gets the old data.
- **Double write to the same address** (both en, both we, a_addr==b_addr):
  - For lanes enabled on both ports, the COLL_PRI port's byte is stored.
  - For lanes enabled on only one port, that port's byte is stored.
  - collision pulses, provided at least one lane overlaps.
- **dout hold:** x_dout holds its last value while x_dout_vld=0. It is never cleared except by rst.
- **Reset mid-operation:** all in-flight pipeline data and valids are discarded, and the INIT sweep restarts from address 0, re-zeroing the memory.

## Timing
- **Reset values:** a_dout=0, b_dout=0, a_dout_vld=0, b_dout_vld=0, collision=0, init_done=0.
- **INIT duration:** init_done rises after exactly DEPTH edges with rst=0. It then stays 1 until the next rst.
- **Latency:**
  - RD_LATENCY=1: dout and dout_vld are registered once and appear at the edge after the request edge.
  - RD_LATENCY=2: one extra output register stage, so they appear 2 edges after the request edge.
- **Pipelining:** both ports accept one request per cycle with no stalls. Back-to-back reads return back-to-back data.
- **collision:** asserted for exactly one cycle, at the edge after the colliding request, independent of RD_LATENCY.
- **Write visibility:** a write at edge N is visible to a read of the same address issued at edge N+1 on either port.
- **Widths:** addresses are used unmodified; all DEPTH entries are reachable and there is no wrap logic.

## Test plan
- **Init sweep:** pulse rst for 2 cycles with DEPTH=16. Expect init_done=0 for 16 edges and 1 after. A read of every address returns 0. A write issued during INIT is dropped: a later read returns 0 and dout_vld never asserted for it.
- **Byte-lane write:** write 0x11223344 to addr 3, then write 0xAABBCCDD to addr 3 with be=4'b0101. A read returns 0x11BB33DD with dout_vld 1 cycle later (RD_LATENCY=1) or 2 cycles later (RD_LATENCY=2).
- **Read-during-write:** mem[5]=0x0, then port A writes 0xCAFEF00D to addr 5 with be=all-ones. RDW_MODE=0 gives a_dout=0xCAFEF00D; RDW_MODE=1 gives 0x0. A port B read of addr 5 in the same cycle returns 0x0.
- **Collision:** both ports write addr 7, A=0xAAAAAAAA be=4'b1110, B=0xBBBBBBBB be=4'b0111. With COLL_PRI=0, mem[7]=0xAAAAAABB and collision pulses once; with COLL_PRI=1, mem[7]=0xAABBBBBB.
- **Streaming:** issue 16 back-to-back reads on both ports. Expect 16 consecutive vld cycles per port with correct data order, and dout held when en drops.
- **Mid-operation reset:** assert rst while reads are in flight with RD_LATENCY=2. Expect all valids 0 on the next edge, init_done=0, and previously written data reading back as 0 after the new sweep.
